spi_cfg_sequencer: RTL and testbench
====================================

SPI_CFG_SEQUENCER -- requirements
Module: spi_cfg_sequencer

Interface
REQ-001 Parameter NUM_WORDS, default 16: boot table depth; the table address width is clog2(NUM_WORDS).
REQ-002 Parameter SYNC_LEN, default 8: SYNC pulse width in clock cycles.
REQ-003 Parameter DONE_TIMEOUT, default 255: maximum cycles to wait for SPI_DONE after SPI_GO.
REQ-004 CLK_1MHZ  in  1  sole clock; all logic is clocked on its rising edge.
REQ-005 RST_N  in  1  reset; asynchronous, active-low.
REQ-006 RECONFIG  in  1  one-cycle request to rerun the boot table.
REQ-007 ROM_ADDR  out  clog2(NUM_WORDS)  boot table address.
REQ-008 ROM_SEL  in  2  target jitter cleaner for the addressed entry; 2'b11 marks end-of-table.
REQ-009 ROM_DATA  in  32  SPI word for the addressed entry; valid combinationally from ROM_ADDR.
REQ-010 HOST_REQ  in  1  host transfer request (level), from the Wishbone register side.
REQ-011 HOST_SEL  in  2  host target select.
REQ-012 HOST_DATA  in  32  host SPI word.
REQ-013 HOST_GRANT  out  1  host transfer in progress.
REQ-014 HOST_DONE  out  1  one-cycle pulse when the host transfer completes.
REQ-015 HOST_RDATA  out  32  SPI readback captured for the host.
REQ-016 SPI_SEL  out  2  slave select to the SPI mux.
REQ-017 SPI_IN  out  32  word to shift out.
REQ-018 SPI_GO  out  1  one-cycle start strobe.
REQ-019 SPI_DONE  in  1  one-cycle completion pulse from the SPI engine.
REQ-020 SPI_OUT  in  32  shifted-in word; valid in the SPI_DONE cycle.
REQ-021 SYNC  out  1  active-high sync request to the jitter cleaners.
REQ-022 CFG_BUSY  out  1  boot sequence active.
REQ-023 CFG_DONE  out  1  boot sequence completed without error.
REQ-024 CFG_ERR  out  1  sticky timeout flag.

Function
REQ-025 States: BOOT_LOAD, BOOT_GO, BOOT_WAIT, SYNC_PULSE, IDLE, HOST_GO, HOST_WAIT.
REQ-026 After reset release, the FSM shall enter BOOT_LOAD with ROM_ADDR=0.
REQ-027 BOOT_LOAD: if ROM_SEL==2'b11 or ROM_ADDR==NUM_WORDS, go to SYNC_PULSE; otherwise register ROM_SEL/ROM_DATA into SPI_SEL/SPI_IN and go to BOOT_GO.
REQ-028 BOOT_GO: assert SPI_GO for exactly one cycle, clear the timeout counter, and go to BOOT_WAIT.
REQ-029 BOOT_WAIT on SPI_DONE: increment ROM_ADDR and return to BOOT_LOAD.
REQ-030 BOOT_WAIT with the counter at DONE_TIMEOUT: set CFG_ERR, increment ROM_ADDR, and return to BOOT_LOAD, so the sequence continues with the next entry.
REQ-031 SYNC_PULSE: hold SYNC high for SYNC_LEN cycles; then CFG_BUSY=0, CFG_DONE=~CFG_ERR, and go to IDLE.
REQ-032 CFG_BUSY shall be 1 in all BOOT_* states and SYNC_PULSE, and 0 otherwise.
REQ-033 IDLE priority: RECONFIG first, then HOST_REQ.
REQ-034 RECONFIG in IDLE: clear CFG_DONE and CFG_ERR, set ROM_ADDR=0, and go to BOOT_LOAD.
REQ-035 HOST_REQ in IDLE: register HOST_SEL/HOST_DATA, set HOST_GRANT=1, and go to HOST_GO.
REQ-036 HOST_GO: assert SPI_GO for one cycle and go to HOST_WAIT.
REQ-037 HOST_WAIT on SPI_DONE: capture SPI_OUT into HOST_RDATA, pulse HOST_DONE, clear HOST_GRANT, and go to IDLE.
REQ-038 HOST_WAIT on timeout: pulse HOST_DONE, set HOST_RDATA=32'hFFFF_FFFF and CFG_ERR, clear HOST_GRANT, and go to IDLE.
REQ-039 A HOST_REQ still high in the cycle after HOST_DONE shall start a new transfer; the host drops HOST_REQ on HOST_DONE.
REQ-040 RECONFIG arriving outside IDLE shall be latched as pending and serviced on the next IDLE entry, ahead of HOST_REQ; multiple pending requests collapse into one.
REQ-041 HOST_REQ during boot shall be held off until boot finishes; HOST_GRANT stays 0 meanwhile.
REQ-042 SPI_DONE outside BOOT_WAIT/HOST_WAIT shall be ignored.
REQ-043 SPI_GO shall never be asserted while a transfer is outstanding.
REQ-044 The timeout counter is 8+ bits wide and saturates; it shall not wrap.

Reset
REQ-045 RST_N=0 shall asynchronously force: state=BOOT_LOAD (held), ROM_ADDR=0, SPI_GO=0, SPI_SEL=0, SPI_IN=0, SYNC=0, HOST_GRANT=0, HOST_DONE=0, HOST_RDATA=0, CFG_BUSY=1, CFG_DONE=0, CFG_ERR=0, pending RECONFIG=0.
REQ-046 Reset asserted mid-transfer shall abandon the transfer; the boot table restarts from entry 0 on release.

Verification
REQ-047 Table {(0,A0),(1,B1),(2,C2),(3,x)}, SPI_DONE 5 cycles after each GO -> exactly 3 GOs with SPI_SEL 0,1,2 in order, then SYNC high 8 cycles, then CFG_DONE=1, CFG_ERR=0.
REQ-048 Full 16-entry table with no terminator -> 16 GOs, ROM_ADDR reaches 16, then SYNC.
REQ-049 SPI_DONE withheld on entry 1 -> after 255 cycles CFG_ERR=1, entry 2 is still sent, and CFG_DONE=0 at the end.
REQ-050 Idle, HOST_REQ with HOST_SEL=2, HOST_DATA=0x12345678, SPI_OUT=0xCAFE0001 -> one GO with SPI_IN=0x12345678 and SPI_SEL=2, then HOST_DONE pulse with HOST_RDATA=0xCAFE0001.
REQ-051 HOST_REQ and RECONFIG in the same IDLE cycle -> boot runs first, and the host is granted after SYNC completes.
REQ-052 RST_N pulsed low during BOOT_WAIT of entry 2 -> outputs take their reset values immediately, and the sequence restarts at ROM_ADDR=0.

Source files
------------

// File: rtl/spi_cfg_sequencer.sv
// spi_cfg_sequencer: walks a boot table of SPI words into the jitter cleaners, pulses SYNC,
// then serves single host SPI transfers; RECONFIG reruns the table.
module spi_cfg_sequencer #(
    parameter int NUM_WORDS    = 16,
    parameter int SYNC_LEN     = 8,
    parameter int DONE_TIMEOUT = 255,
    localparam int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic          i_clk_1mhz,
    input  logic          i_rst_n,
    input  logic          i_reconfig,
    output logic [AW-1:0] o_rom_addr,
    input  logic [1:0]    i_rom_sel,
    input  logic [31:0]   i_rom_data,
    input  logic          i_host_req,
    input  logic [1:0]    i_host_sel,
    input  logic [31:0]   i_host_data,
    output logic          o_host_grant,
    output logic          o_host_done,
    output logic [31:0]   o_host_rdata,
    output logic [1:0]    o_spi_sel,
    output logic [31:0]   o_spi_in,
    output logic          o_spi_go,
    input  logic          i_spi_done,
    input  logic [31:0]   i_spi_out,
    output logic          o_sync,
    output logic          o_cfg_busy,
    output logic          o_cfg_done,
    output logic          o_cfg_err
);
    localparam int CMAX = (DONE_TIMEOUT > SYNC_LEN) ? DONE_TIMEOUT : SYNC_LEN;
    localparam int CW   = ($clog2(CMAX + 1) > 8) ? $clog2(CMAX + 1) : 8;

    typedef enum logic [2:0] {
        BOOT_LOAD, BOOT_GO, BOOT_WAIT, SYNC_PULSE, IDLE, HOST_GO, HOST_WAIT
    } state_t;

    state_t        r_state, w_next;
    // one extra bit so the address can reach NUM_WORDS on a table with no terminator
    logic [AW:0]   r_addr;
    logic [CW-1:0] r_cnt;
    logic          r_pend, r_host_done, r_cfg_done, r_cfg_err;
    logic [1:0]    r_spi_sel;
    logic [31:0]   r_spi_in, r_host_rdata;
    logic          w_waiting, w_timeout, w_table_end, w_sync_end, w_boot_req, w_host_start;

    assign w_waiting    = (r_state == BOOT_WAIT) || (r_state == HOST_WAIT);
    assign w_timeout    = r_cnt == CW'(DONE_TIMEOUT);
    assign w_table_end  = (r_addr == (AW+1)'(NUM_WORDS)) || (i_rom_sel == 2'b11);
    assign w_sync_end   = r_cnt == CW'(SYNC_LEN - 1);
    assign w_boot_req   = i_reconfig || r_pend;
    // a request still high during the HOST_DONE cycle is the old one; sample it a cycle later
    assign w_host_start = i_host_req && !r_host_done;

    always_ff @(posedge i_clk_1mhz or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= BOOT_LOAD;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            BOOT_LOAD:  w_next = w_table_end ? SYNC_PULSE : BOOT_GO;
            BOOT_GO:    w_next = BOOT_WAIT;
            BOOT_WAIT:  w_next = (i_spi_done || w_timeout) ? BOOT_LOAD : BOOT_WAIT;
            SYNC_PULSE: w_next = w_sync_end ? IDLE : SYNC_PULSE;
            IDLE:       w_next = w_boot_req ? BOOT_LOAD : (w_host_start ? HOST_GO : IDLE);
            HOST_GO:    w_next = HOST_WAIT;
            HOST_WAIT:  w_next = (i_spi_done || w_timeout) ? IDLE : HOST_WAIT;
            default:    w_next = BOOT_LOAD;
        endcase
    end

    always_ff @(posedge i_clk_1mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr       <= '0;
            r_cnt        <= '0;
            r_pend       <= 1'b0;
            r_host_done  <= 1'b0;
            r_cfg_done   <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_spi_sel    <= '0;
            r_spi_in     <= '0;
            r_host_rdata <= '0;
        end else begin
            r_host_done <= 1'b0;
            r_cnt       <= (w_waiting || r_state == SYNC_PULSE) ? ((&r_cnt) ? r_cnt : r_cnt + 1'b1) : '0;
            r_pend      <= (r_state == IDLE) ? 1'b0 : (r_pend | i_reconfig);
            case (r_state)
                BOOT_LOAD: begin
                    if (!w_table_end) begin
                        r_spi_sel <= i_rom_sel;
                        r_spi_in  <= i_rom_data;
                    end
                end
                BOOT_WAIT: begin
                    if (i_spi_done || w_timeout) begin
                        r_addr    <= r_addr + 1'b1;
                        r_cfg_err <= r_cfg_err | !i_spi_done;
                    end
                end
                SYNC_PULSE: begin
                    if (w_sync_end)
                        r_cfg_done <= !r_cfg_err;
                end
                IDLE: begin
                    if (w_boot_req) begin
                        r_cfg_done <= 1'b0;
                        r_cfg_err  <= 1'b0;
                        r_addr     <= '0;
                    end else if (w_host_start) begin
                        r_spi_sel <= i_host_sel;
                        r_spi_in  <= i_host_data;
                    end
                end
                HOST_WAIT: begin
                    if (i_spi_done || w_timeout) begin
                        r_host_done  <= 1'b1;
                        r_host_rdata <= i_spi_done ? i_spi_out : '1;
                        r_cfg_err    <= r_cfg_err | !i_spi_done;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_rom_addr   = r_addr[AW-1:0];
    assign o_spi_sel    = r_spi_sel;
    assign o_spi_in     = r_spi_in;
    assign o_spi_go     = (r_state == BOOT_GO) || (r_state == HOST_GO);
    assign o_sync       = r_state == SYNC_PULSE;
    assign o_cfg_busy   = (r_state == BOOT_LOAD) || (r_state == BOOT_GO) || (r_state == BOOT_WAIT) || (r_state == SYNC_PULSE);
    assign o_host_grant = (r_state == HOST_GO) || (r_state == HOST_WAIT);
    assign o_host_done  = r_host_done;
    assign o_host_rdata = r_host_rdata;
    assign o_cfg_done   = r_cfg_done;
    assign o_cfg_err    = r_cfg_err;
endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// tb_spi_cfg_sequencer: scoreboard bench; a table-walking reference model queues expected
// SPI transfers, SYNC outcomes and host completions, and a monitor checks them as they appear.
module tb_spi_cfg_sequencer;
    localparam int NW = 16;
    localparam int SL = 8;
    localparam int K_GO = 0;
    localparam int K_SYNC = 1;
    localparam int K_HOST = 2;

    logic        clk = 0, rst_n = 1, reconfig = 0, host_req = 0, spi_done = 0;
    logic [1:0]  host_sel = 0;
    logic [31:0] host_data = 0, spi_out = 0;
    logic [3:0]  rom_addr;
    logic [1:0]  rom_sel_w, spi_sel;
    logic [31:0] rom_data_w, host_rdata, spi_in;
    logic        host_grant, host_done, spi_go, sync, cfg_busy, cfg_done, cfg_err;
    logic [1:0]  rom_sel [NW];
    logic [31:0] rom_data [NW];

    assign rom_sel_w  = rom_sel[rom_addr];
    assign rom_data_w = rom_data[rom_addr];

    spi_cfg_sequencer dut (
        .i_clk_1mhz(clk), .i_rst_n(rst_n), .i_reconfig(reconfig),
        .o_rom_addr(rom_addr), .i_rom_sel(rom_sel_w), .i_rom_data(rom_data_w),
        .i_host_req(host_req), .i_host_sel(host_sel), .i_host_data(host_data),
        .o_host_grant(host_grant), .o_host_done(host_done), .o_host_rdata(host_rdata),
        .o_spi_sel(spi_sel), .o_spi_in(spi_in), .o_spi_go(spi_go),
        .i_spi_done(spi_done), .i_spi_out(spi_out), .o_sync(sync),
        .o_cfg_busy(cfg_busy), .o_cfg_done(cfg_done), .o_cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0, errors = 0, go_count = 0, hold_at = -1, gen = 0;
    logic [31:0] resp_data = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic miss(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic void push(input int k, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        exp_t e;
        e.kind = k;
        e.a = a;
        e.b = b;
        e.c = c;
        exp_q.push_back(e);
    endfunction

    function automatic void make_table(input int len);
        for (int i = 0; i < NW; i++) begin
            rom_sel[i]  = (i < len) ? 2'($urandom_range(0, 2)) : ((i == len) ? 2'b11 : 2'($urandom_range(0, 3)));
            rom_data[i] = $urandom;
        end
    endfunction

    // reference: every entry before the first terminator is sent in order; one withheld entry ruins CFG_DONE
    function automatic void push_boot(input int hold);
        int n;
        n = 0;
        while (n < NW && rom_sel[n] != 2'b11) begin
            push(K_GO, 32'(rom_sel[n]), rom_data[n], 0);
            n++;
        end
        push(K_SYNC, (hold >= 0 && hold < n) ? 0 : 1, (hold >= 0 && hold < n) ? 1 : 0, n);
    endfunction

    task automatic reset_checks(input string tag);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
        chk({tag, "_spi_go"}, 32'(spi_go), 0);
        chk({tag, "_spi_sel"}, 32'(spi_sel), 0);
        chk({tag, "_spi_in"}, spi_in, 0);
        chk({tag, "_sync"}, 32'(sync), 0);
        chk({tag, "_host_grant"}, 32'(host_grant), 0);
        chk({tag, "_host_done"}, 32'(host_done), 0);
        chk({tag, "_host_rdata"}, host_rdata, 0);
        chk({tag, "_cfg_busy"}, 32'(cfg_busy), 1);
        chk({tag, "_cfg_done"}, 32'(cfg_done), 0);
        chk({tag, "_cfg_err"}, 32'(cfg_err), 0);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || cfg_busy || host_grant) && n < 3000);
        if (n >= 3000)
            miss({tag, "_drain"}, $sformatf("%0d expectations still queued after 3000 cycles", exp_q.size()));
    endtask

    task automatic pulse_reconfig();
        @(negedge clk);
        reconfig = 1;
        @(negedge clk);
        reconfig = 0;
    endtask

    task automatic reboot(input int len, input int hold);
        make_table(len);
        push_boot(hold);
        hold_at = (hold >= 0) ? go_count + hold : -1;
        pulse_reconfig();
        wait_drain($sformatf("boot%0d", len));
    endtask

    task automatic host_xfer(input logic [1:0] sel, input logic [31:0] data, input logic [31:0] resp,
                             input bit tmo, input bit rc);
        int n;
        resp_data = resp;
        hold_at   = tmo ? go_count : -1;
        push(K_GO, 32'(sel), data, 0);
        push(K_HOST, 0, tmo ? 32'hFFFF_FFFF : resp, 0);
        host_sel  = sel;
        host_data = data;
        host_req  = 1;
        reconfig  = rc;
        @(negedge clk);
        reconfig = 0;
        n = 0;
        while (!host_grant && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) miss("host_grant_wait", "no grant within 2000 cycles");
        host_req = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!host_done && n < 600);
        if (n >= 600) miss("host_done_wait", "no HOST_DONE within 600 cycles");
    endtask

    // SPI engine: answers each GO after 1..6 cycles unless that GO is the one being withheld
    initial begin
        int idx, g, d;
        forever begin
            @(negedge clk);
            if (spi_go && rst_n) begin
                idx = go_count;
                g   = gen;
                go_count++;
                if (idx != hold_at) begin
                    d = $urandom_range(1, 6);
                    repeat (d) @(negedge clk);
                    if (g == gen && rst_n) begin
                        spi_done = 1;
                        spi_out  = resp_data;
                        @(negedge clk);
                        spi_done = 0;
                    end
                end
            end
        end
    end

    initial begin
        int   sync_n;
        exp_t e;
        sync_n = 0;
        forever begin
            @(negedge clk);
            if (cfg_busy) chk("grant_during_boot", 32'(host_grant), 0);
            if (spi_go) begin
                if (exp_q.size() == 0 || exp_q[0].kind != K_GO)
                    miss("go_unexpected", $sformatf("GO sel %0d data %h with no transfer expected", spi_sel, spi_in));
                else begin
                    e = exp_q.pop_front();
                    chk("go_sel", 32'(spi_sel), e.a);
                    chk("go_data", spi_in, e.b);
                end
            end
            if (sync)
                sync_n++;
            else if (sync_n != 0) begin
                if (exp_q.size() == 0 || exp_q[0].kind != K_SYNC)
                    miss("sync_unexpected", $sformatf("SYNC of %0d cycles not expected", sync_n));
                else begin
                    e = exp_q.pop_front();
                    chk("sync_len", sync_n, SL);
                    chk("cfg_done", 32'(cfg_done), e.a);
                    chk("cfg_err", 32'(cfg_err), e.b);
                    chk("end_rom_addr", 32'(rom_addr), {28'b0, e.c[3:0]});
                    chk("busy_after_sync", 32'(cfg_busy), 0);
                end
                sync_n = 0;
            end
            if (host_done) begin
                if (exp_q.size() == 0 || exp_q[0].kind != K_HOST)
                    miss("host_done_unexpected", $sformatf("HOST_DONE rdata %h not expected", host_rdata));
                else begin
                    e = exp_q.pop_front();
                    chk("host_rdata", host_rdata, e.b);
                    chk("grant_at_done", 32'(host_grant), 0);
                end
            end
            if (!rst_n) sync_n = 0;
        end
    end

    initial begin
        int base, n;
        make_table(3);
        rom_sel[0] = 0; rom_data[0] = 32'hA0;
        rom_sel[1] = 1; rom_data[1] = 32'hB1;
        rom_sel[2] = 2; rom_data[2] = 32'hC2;
        #2 rst_n = 0;
        repeat (3) @(negedge clk);
        reset_checks("por");
        push_boot(-1);
        rst_n = 1;
        wait_drain("boot_directed");
        host_xfer(2'd2, 32'h1234_5678, 32'hCAFE_0001, 0, 0);
        wait_drain("host_directed");
        for (int it = 0; it < 5; it++) begin
            reboot($urandom_range(0, NW), -1);
            host_xfer(2'($urandom_range(0, 2)), $urandom, $urandom, 0, 0);
            host_xfer(2'($urandom_range(0, 2)), $urandom, $urandom, 0, 0);
            wait_drain("host_pair");
        end
        reboot(NW, -1);
        reboot(4, 1);
        make_table(3);
        push_boot(-1);
        hold_at = -1;
        @(negedge clk);
        host_xfer(2'd1, $urandom, $urandom, 0, 1);
        wait_drain("reconfig_with_host");
        make_table(4);
        push_boot(-1);
        push_boot(-1);
        hold_at = -1;
        pulse_reconfig();
        repeat (3) @(negedge clk);
        pulse_reconfig();
        pulse_reconfig();
        wait_drain("pending_reconfig");
        host_xfer(2'd0, $urandom, $urandom, 1, 0);
        chk("host_timeout_err", 32'(cfg_err), 1);
        make_table(5);
        push_boot(-1);
        base = go_count;
        hold_at = base + 2;
        pulse_reconfig();
        n = 0;
        while (go_count < base + 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) miss("reach_entry2", "third boot GO never seen");
        repeat (2) @(negedge clk);
        rst_n = 0;
        gen++;
        #1 reset_checks("mid_reset");
        exp_q.delete();
        hold_at = -1;
        push_boot(-1);
        repeat (2) @(negedge clk);
        rst_n = 1;
        wait_drain("boot_after_reset");
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
